// File: rtl/mult_div_unit_pkg.sv
// Shared MDU operation encodings and FSM state type for the execute-stage multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Bundle between the pipeline controller and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  import mult_div_unit_pkg::*;

  // Handshake: op is taken only on a rising edge where busy is low. While busy
  // is high every op is dropped (no queueing), so the controller must stall.
  mdu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  mdu_state_e       state;

  modport master (output op, a, b, input busy, hi, lo, state);
  modport slave  (input op, a, b, output busy, hi, lo, state);

endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. The result is computed
// at issue, held in a temp latch, and committed after a fixed per-op latency.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  mdu
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic             commit_q, commit_d;

  logic [2*WIDTH-1:0] sprod, uprod;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, den, uq, ur, quot, rem;

  assign sprod = {{WIDTH{mdu.a[WIDTH-1]}}, mdu.a} * {{WIDTH{mdu.b[WIDTH-1]}}, mdu.b};
  assign uprod = {{WIDTH{1'b0}}, mdu.a} * {{WIDTH{1'b0}}, mdu.b};

  // Signed divide via magnitudes: MIN_INT/-1 wraps to MIN_INT with no trap.
  assign a_neg  = (mdu.op == MDU_DIV) && mdu.a[WIDTH-1];
  assign b_neg  = (mdu.op == MDU_DIV) && mdu.b[WIDTH-1];
  assign b_zero = (mdu.b == '0);
  assign a_mag  = a_neg ? -mdu.a : mdu.a;
  assign b_mag  = b_neg ? -mdu.b : mdu.b;
  assign den    = b_zero ? WIDTH'(1) : b_mag;
  assign uq     = a_mag / den;
  assign ur     = a_mag % den;
  assign quot   = (a_neg ^ b_neg) ? -uq : uq;
  assign rem    = a_neg ? -ur : ur;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    commit_d = commit_q;
    case (state_q)
      ST_IDLE: begin
        case (mdu.op)
          MDU_MULT, MDU_MULTU: begin
            {tmp_hi_d, tmp_lo_d} = (mdu.op == MDU_MULT) ? sprod : uprod;
            commit_d = 1'b1;
            cnt_d    = MULT_LOAD;
            state_d  = ST_RUN;
          end
          MDU_DIV, MDU_DIVU: begin
            tmp_hi_d = rem;
            tmp_lo_d = quot;
            commit_d = !b_zero;
            cnt_d    = DIV_LOAD;
            state_d  = ST_RUN;
          end
          MDU_MTHI: hi_d = mdu.a;
          MDU_MTLO: lo_d = mdu.a;
          default: ;
        endcase
      end
      ST_RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (commit_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      commit_q <= commit_d;
    end
  end

  assign mdu.busy  = (state_q == ST_RUN);
  assign mdu.hi    = hi_q;
  assign mdu.lo    = lo_q;
  assign mdu.state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, arithmetic, ignore-while-busy, divide by zero, async reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) mdu_if ();

  mult_div_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu_if)
  );

  // Called at a negedge: present op for one rising edge, then return to NONE.
  task automatic drive(input mdu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    mdu_if.op = op;
    mdu_if.a  = a;
    mdu_if.b  = b;
    @(negedge clk);
    mdu_if.op = MDU_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (mdu_if.busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mdu_if.op = MDU_NONE;
    mdu_if.a  = '0;
    mdu_if.b  = '0;
    repeat (3) @(negedge clk);
    checks++; if (mdu_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", mdu_if.busy); end
    checks++; if (mdu_if.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", mdu_if.hi); end
    checks++; if (mdu_if.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", mdu_if.lo); end
    checks++; if (mdu_if.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", mdu_if.state); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int n;
    drive(MDU_MTHI, 32'h55, 32'h0);
    drive(MDU_MTLO, 32'h66, 32'h0);
    checks++; if (mdu_if.hi !== 32'h55 || mdu_if.lo !== 32'h66) begin errors++; $display("FAIL mthi_mtlo_preset: got %h/%h expected 00000055/00000066", mdu_if.hi, mdu_if.lo); end
    drive(MDU_MULT, 32'hFFFF_FFFD, 32'h5);
    checks++; if (mdu_if.state !== ST_RUN) begin errors++; $display("FAIL mult_state_run: got %0d expected 1", mdu_if.state); end
    n = 0;
    while (mdu_if.busy === 1'b1 && n < 50) begin
      checks++;
      if (mdu_if.hi !== 32'h55 || mdu_if.lo !== 32'h66) begin errors++; $display("FAIL mult_hold: got %h/%h expected 00000055/00000066", mdu_if.hi, mdu_if.lo); end
      n++;
      @(negedge clk);
    end
    checks++; if (n != MC) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected %0d", n, MC); end
    checks++; if (mdu_if.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", mdu_if.hi); end
    checks++; if (mdu_if.lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h expected fffffff1", mdu_if.lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    drive(MDU_MULTU, 32'hFFFF_FFFF, 32'h2);
    wait_idle(n);
    checks++; if (n != MC) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected %0d", n, MC); end
    checks++; if (mdu_if.hi !== 32'h1) begin errors++; $display("FAIL multu_hi: got %h expected 00000001", mdu_if.hi); end
    checks++; if (mdu_if.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", mdu_if.lo); end
    drive(MDU_DIVU, 32'h7, 32'h2);
    wait_idle(n);
    checks++; if (n != DC) begin errors++; $display("FAIL divu_busy_cycles: got %0d expected %0d", n, DC); end
    checks++; if (mdu_if.lo !== 32'h3) begin errors++; $display("FAIL divu_lo: got %h expected 00000003", mdu_if.lo); end
    checks++; if (mdu_if.hi !== 32'h1) begin errors++; $display("FAIL divu_hi: got %h expected 00000001", mdu_if.hi); end
  endtask

  task automatic test_div();
    int n;
    drive(MDU_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_idle(n);
    checks++; if (n != DC) begin errors++; $display("FAIL div_busy_cycles: got %0d expected %0d", n, DC); end
    checks++; if (mdu_if.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", mdu_if.lo); end
    checks++; if (mdu_if.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", mdu_if.hi); end
    drive(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++; if (mdu_if.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", mdu_if.lo); end
    checks++; if (mdu_if.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", mdu_if.hi); end
    drive(MDU_DIV, 32'h7, 32'hFFFF_FFFE);
    wait_idle(n);
    checks++; if (mdu_if.lo !== 32'hFFFF_FFFD || mdu_if.hi !== 32'h1) begin errors++; $display("FAIL div_pos_neg: got %h/%h expected 00000001/fffffffd", mdu_if.hi, mdu_if.lo); end
  endtask

  task automatic test_ignore_busy();
    int n;
    drive(MDU_DIV, 32'd100, 32'd7);
    drive(MDU_MTHI, 32'h1234, 32'h0);
    drive(MDU_MULT, 32'h3, 32'h3);
    wait_idle(n);
    checks++; if (n != DC - 2) begin errors++; $display("FAIL ignore_busy_cycles: got %0d expected %0d", n, DC - 2); end
    checks++; if (mdu_if.hi !== 32'd2) begin errors++; $display("FAIL ignore_hi: got %h expected 00000002", mdu_if.hi); end
    checks++; if (mdu_if.lo !== 32'd14) begin errors++; $display("FAIL ignore_lo: got %h expected 0000000e", mdu_if.lo); end
    drive(MDU_MTLO, 32'hABCD, 32'h0);
    checks++; if (mdu_if.lo !== 32'hABCD) begin errors++; $display("FAIL mtlo_lo: got %h expected 0000abcd", mdu_if.lo); end
    checks++; if (mdu_if.hi !== 32'd2) begin errors++; $display("FAIL mtlo_hi_untouched: got %h expected 00000002", mdu_if.hi); end
    checks++; if (mdu_if.busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b expected 0", mdu_if.busy); end
  endtask

  task automatic test_div_zero();
    int n;
    drive(MDU_MTHI, 32'h11, 32'h0);
    drive(MDU_MTLO, 32'h22, 32'h0);
    drive(MDU_DIV, 32'h5, 32'h0);
    wait_idle(n);
    checks++; if (n != DC) begin errors++; $display("FAIL divz_busy_cycles: got %0d expected %0d", n, DC); end
    checks++; if (mdu_if.hi !== 32'h11) begin errors++; $display("FAIL divz_hi: got %h expected 00000011", mdu_if.hi); end
    checks++; if (mdu_if.lo !== 32'h22) begin errors++; $display("FAIL divz_lo: got %h expected 00000022", mdu_if.lo); end
  endtask

  task automatic test_async_reset();
    int n;
    drive(MDU_MULT, 32'd7, 32'd9);
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++; if (mdu_if.busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b expected 1", mdu_if.busy); end
    #1 reset = 1'b1;
    #1;
    checks++; if (mdu_if.busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", mdu_if.busy); end
    checks++; if (mdu_if.hi !== 32'h0 || mdu_if.lo !== 32'h0) begin errors++; $display("FAIL areset_hilo: got %h/%h expected 00000000/00000000", mdu_if.hi, mdu_if.lo); end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (mdu_if.busy !== 1'b0 || mdu_if.lo !== 32'h0 || mdu_if.hi !== 32'h0) begin errors++; $display("FAIL areset_no_commit: got busy=%b %h/%h expected busy=0 00000000/00000000", mdu_if.busy, mdu_if.hi, mdu_if.lo); end
    drive(MDU_MULT, 32'd2, 32'd3);
    wait_idle(n);
    checks++; if (n != MC) begin errors++; $display("FAIL areset_mult_cycles: got %0d expected %0d", n, MC); end
    checks++; if (mdu_if.lo !== 32'd6 || mdu_if.hi !== 32'd0) begin errors++; $display("FAIL areset_mult: got %h/%h expected 00000000/00000006", mdu_if.hi, mdu_if.lo); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_ignore_busy();
    test_div_zero();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers, parametrised in operand width and per-operation latency. It is the sequential companion to the combinational ALU in the execute stage. It serves MULT/MULTU/DIV/DIVU/MTHI/MTLO and exposes HI/LO for MFHI/MFLO. A busy flag lets the pipeline controller stall HI/LO consumers and new MDU ops while a computation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width in bits
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
op  input  3  MDU operation: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 treated as NONE
a  input  WIDTH  operand rs (dividend / multiplicand / MTHI-MTLO source)
b  input  WIDTH  operand rt (divisor / multiplier)
busy  output  1  high while a MULT/DIV result is pending
hi  output  WIDTH  architectural HI register
lo  output  WIDTH  architectural LO register

Behaviour:
- Reset (async, any time, including mid-operation): busy=0, hi=0, lo=0, counter=0, pending result discarded. Outputs follow reset immediately, not at the next edge.
- Issue rule: op is sampled only on a rising edge with busy==0. Any op while busy==1 is ignored; the controller must stall. No queueing is performed.
- States: IDLE (busy=0) and RUN (busy=1, counter>0).
- IDLE, op=MULT/MULTU at edge k:
  - Full 2*WIDTH product computed from a,b and latched into temp_hi/temp_lo.
  - counter loads MULT_CYCLES; busy=1 during cycles k+1 .. k+MULT_CYCLES.
  - At edge k+MULT_CYCLES: hi/lo <= temp, busy falls to 0.
  - The unit accepts a new op at edge k+MULT_CYCLES+1.
- DIV/DIVU follow the same sequence with DIV_CYCLES.
- hi/lo hold their old values throughout RUN. They change only at the commit edge.
- MULT: signed x signed. MULTU: unsigned. hi = upper WIDTH bits, lo = lower WIDTH bits.
- DIV: signed. lo = quotient truncated toward zero. hi = remainder with the sign of the dividend.
  - Overflow case a=MIN_INT, b=-1: lo=MIN_INT, hi=0 (wrap, no trap).
- DIVU: unsigned. lo = quotient, hi = remainder.
- Divide by zero (b==0, DIV or DIVU): full DIV_CYCLES busy period still occurs; hi/lo are left unchanged at commit.
- MTHI/MTLO in IDLE: hi (resp. lo) <= a at that edge. Single cycle; busy stays 0; the other register is untouched.
- Operands are captured at issue. Changes to a/b during RUN have no effect.
- No combinational path from op/a/b to busy/hi/lo. All outputs are registered.

Decomposition:
- Op encodings MDU_NONE..MDU_MTLO go in the shared constants include alongside the ALU control codes. The decode stage and this block use the same constants.
- No sub-module is required. The latency counter and result latch are inline.
- The arithmetic is behavioural (* and / with $signed casts); no iterative divider is needed at this latency model.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> busy high exactly 5 cycles; after commit hi=0xFFFFFFFF, lo=0xFFFFFFF1. hi/lo unchanged during busy.
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE. DIVU a=7, b=2 -> lo=3, hi=1 after 10 busy cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue DIV, then assert op=MTHI a=0x1234 and op=MULT during busy -> both ignored; final hi/lo equal the DIV result only. After busy falls, MTLO a=0xABCD -> lo=0xABCD next edge, busy stays 0.
- Preset hi=0x11, lo=0x22 via MTHI/MTLO; DIV by b=0 -> busy 10 cycles, hi=0x11, lo=0x22 afterward.
- Assert reset asynchronously (mid-cycle) during cycle 3 of a MULT -> busy, hi, lo go to 0 immediately. After release the old result never commits, and a new MULT 2x3 yields lo=6, hi=0.
